// File: rtl/addr4u_result_checker.sv
// Operand register, result checker and retry/fault tracker around an external 4-bit adder.
// Optional build macro ADDR4U_CORRECT_EN: deliver the golden sum on a final mismatch.
module addr4u_result_checker #(
  parameter int MAX_RETRY    = 2,
  parameter int FAULT_THRESH = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_a,
  input  logic [3:0]           in_b,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  input  logic [4:0]           add_o,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_sum,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 fault,
  input  logic                 clr_fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [2:0]           MAX_RETRY_C    = 3'(MAX_RETRY);
  localparam logic [3:0]           FAULT_THRESH_C = 4'(FAULT_THRESH);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX        = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE        = ERR_CNT_W'(1);

  state_e               state_q,     state_d;
  logic [3:0]           a_q,         a_d;
  logic [3:0]           b_q,         b_d;
  logic [2:0]           retry_q,     retry_d;
  logic [3:0]           consec_q,    consec_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [4:0]           out_sum_q,   out_sum_d;
  logic                 out_err_q,   out_err_d;
  logic                 fault_q,     fault_d;

  logic                 slot_free;
  logic [4:0]           golden_sum;
  logic [4:0]           final_sum;
  logic [3:0]           consec_inc;

  assign slot_free  = !out_valid_q || out_ready;
  assign golden_sum = {1'b0, a_q} + {1'b0, b_q};
  assign consec_inc = consec_q + 4'd1;

`ifdef ADDR4U_CORRECT_EN
  assign final_sum = golden_sum;
`else
  assign final_sum = add_o;
`endif

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;
  assign fault     = fault_q;

  // Next-state, operand capture, compare/retry and output-slot logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    retry_d     = retry_q;
    consec_d    = consec_q;
    err_cnt_d   = err_cnt_q;
    out_sum_d   = out_sum_q;
    out_err_d   = out_err_q;
    fault_d     = fault_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          retry_d = 3'd0;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CHECK: begin
        // A full slot freezes the compare so stalls never consume retries.
        if (!slot_free) begin
          state_d = ST_CHECK;
        end else if (add_o == golden_sum) begin
          out_sum_d   = add_o;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          consec_d    = 4'd0;
          state_d     = ST_IDLE;
        end else if (retry_q < MAX_RETRY_C) begin
          retry_d = retry_q + 3'd1;
          state_d = ST_CHECK;
        end else begin
          out_sum_d   = final_sum;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          consec_d    = consec_inc;
          if (err_cnt_q == ERR_MAX) begin
            err_cnt_d = err_cnt_q;
          end else begin
            err_cnt_d = err_cnt_q + ERR_ONE;
          end
          if (consec_inc == FAULT_THRESH_C) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_FAULT: begin
        if (clr_fault) begin
          fault_d  = 1'b0;
          consec_d = 4'd0;
          state_d  = ST_IDLE;
        end else begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      retry_q     <= 3'd0;
      consec_q    <= 4'd0;
      err_cnt_q   <= {ERR_CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_sum_q   <= 5'd0;
      out_err_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      retry_q     <= retry_d;
      consec_q    <= consec_d;
      err_cnt_q   <= err_cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_err_q   <= out_err_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_addr4u_result_checker.sv
// Self-checking bench for addr4u_result_checker: directed scenarios plus randomized traffic
// against a transaction-level model. The adder is modelled here with a fault-injection override.
module tb_addr4u_result_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [4:0] add_o;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_sum;
  logic       out_err;
  logic [7:0] err_cnt;
  logic       fault;
  logic       clr_fault = 1'b0;

  logic       force_en = 1'b0;
  logic [4:0] force_val = 5'd0;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_err = 0;

  assign add_o = force_en ? force_val : ({1'b0, add_a} + {1'b0, add_b});

  always #5 clk = ~clk;

  addr4u_result_checker #(.MAX_RETRY(2), .FAULT_THRESH(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
    .err_cnt(err_cnt), .fault(fault), .clr_fault(clr_fault)
  );

  function automatic logic [4:0] final_mismatch_sum(input logic [4:0] golden, input logic [4:0] bad);
`ifdef ADDR4U_CORRECT_EN
    return golden;
`else
    return bad;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clr_fault = 1'b0; force_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    exp_err = 0;
  endtask

  // Presents an operand pair and returns just after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 20) begin tick(); n++; end
    tests_run++;
    if (!in_ready) begin
      tests_failed++;
      $display("FAIL send_accept: in_ready=%0d required 1 within 20 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin tick(); cycles++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_a = 4'd5; in_b = 4'd6;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_in_ready: got %0d required 0", in_ready);
      end
    end
    in_valid = 1'b0; rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || err_cnt !== 8'd0 || fault !== 1'b0 || in_ready !== 1'b1 ||
        out_sum !== 5'd0 || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%0d cnt=%0d fault=%0d rdy=%0d sum=%0d err=%0d required 0 0 0 1 0 0",
               out_valid, err_cnt, fault, in_ready, out_sum, out_err);
    end
    exp_err = 0;
  endtask

  task automatic test_clean_add();
    int c;
    out_ready = 1'b1;
    send(4'd9, 4'd7);
    wait_out(c);
    tests_run++;
    if (c != 1 || out_sum !== 5'd16 || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL clean_9_7: lat=%0d sum=%0d err=%0d required 1 16 0", c, out_sum, out_err);
    end
    tick();
    send(4'd15, 4'd15);
    wait_out(c);
    tests_run++;
    if (c != 1 || out_sum !== 5'd30 || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL clean_15_15: lat=%0d sum=%0d err=%0d required 1 30 0", c, out_sum, out_err);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL clean_drain: out_valid=%0d required 0", out_valid);
    end
  endtask

  task automatic test_transient();
    out_ready = 1'b1;
    send(4'd3, 4'd4);
    force_en = 1'b1; force_val = 5'd0;
    tick();
    force_en = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL transient_early: out_valid=%0d required 0", out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 5'd7 || out_err !== 1'b0 || err_cnt !== 8'(exp_err)) begin
      tests_failed++;
      $display("FAIL transient_result: valid=%0d sum=%0d err=%0d cnt=%0d required 1 7 0 %0d",
               out_valid, out_sum, out_err, err_cnt, exp_err);
    end
    tick();
  endtask

  task automatic test_persistent();
    int c;
    logic [4:0] exp_sum;
    out_ready = 1'b1;
    force_en = 1'b1; force_val = 5'h1F;
    send(4'd2, 4'd2);
    wait_out(c);
    exp_err++;
    exp_sum = final_mismatch_sum(5'd4, 5'd31);
    tests_run++;
    if (c != 3 || out_sum !== exp_sum || out_err !== 1'b1 || err_cnt !== 8'(exp_err)) begin
      tests_failed++;
      $display("FAIL persistent: lat=%0d sum=%0d err=%0d cnt=%0d required 3 %0d 1 %0d",
               c, out_sum, out_err, err_cnt, exp_sum, exp_err);
    end
    force_en = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int c;
    out_ready = 1'b0;
    send(4'd5, 4'd6);
    wait_out(c);
    tests_run++;
    if (out_sum !== 5'd11 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_first: valid=%0d sum=%0d required 1 11", out_valid, out_sum);
    end
    send(4'd1, 4'd1);
    force_en = 1'b1; force_val = 5'd0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_sum !== 5'd11 || out_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold: cycle=%0d valid=%0d sum=%0d err=%0d required 1 11 0",
                 i, out_valid, out_sum, out_err);
      end
      tick();
    end
    force_en = 1'b0; out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 5'd2 || out_err !== 1'b0 || err_cnt !== 8'(exp_err)) begin
      tests_failed++;
      $display("FAIL bp_second: valid=%0d sum=%0d err=%0d cnt=%0d required 1 2 0 %0d",
               out_valid, out_sum, out_err, err_cnt, exp_err);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: out_valid=%0d required 0", out_valid);
    end
  endtask

  task automatic test_fault_threshold();
    int c;
    do_reset();
    out_ready = 1'b1;
    force_en = 1'b1; force_val = 5'h1F;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
      end
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      wait_out(c);
      exp_err++;
      tests_run++;
      if (out_err !== 1'b1 || err_cnt !== 8'(exp_err) || fault !== (i == 3)) begin
        tests_failed++;
        $display("FAIL thresh_txn%0d: err=%0d cnt=%0d fault=%0d required 1 %0d %0d",
                 i, out_err, err_cnt, fault, exp_err, (i == 3));
      end
      tick();
    end
    force_en = 1'b0;
    in_valid = 1'b1; in_a = 4'd1; in_b = 4'd2;
    tick(); tick();
    tests_run++;
    if (fault !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL thresh_hold: fault=%0d rdy=%0d valid=%0d required 1 0 0", fault, in_ready, out_valid);
    end
    in_valid = 1'b0;
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    tests_run++;
    if (fault !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 8'd4) begin
      tests_failed++;
      $display("FAIL thresh_clear: fault=%0d rdy=%0d cnt=%0d required 0 1 4", fault, in_ready, err_cnt);
    end
  endtask

  // Randomized traffic against a transaction-level scoreboard.
  task automatic test_random();
    logic [4:0] q_sum[$];
    logic       q_err[$];
    int         q_cnt[$];
    logic       q_fault[$];
    int         m_err = 0;
    int         m_consec = 0;
    int         delivered = 0;
    logic [4:0] gold;
    logic       dlv;
    logic       acc;
    do_reset();
    for (int cyc = 0; cyc < 6040; cyc++) begin
      clr_fault = fault && !out_valid;
      if (in_ready && cyc < 6000 && $urandom_range(0, 3) != 0) begin
        in_a = 4'($urandom_range(0, 15));
        in_b = 4'($urandom_range(0, 15));
        in_valid = 1'b1;
        gold = 5'(in_a) + 5'(in_b);
        force_en = ($urandom_range(0, 3) == 0);
        force_val = gold ^ 5'($urandom_range(1, 31));
      end
      out_ready = (cyc >= 6000) ? 1'b1 : ($urandom_range(0, 2) != 0);
      dlv = out_valid && out_ready;
      acc = in_valid && in_ready;
      if (dlv) begin
        delivered++;
        tests_run++;
        if (q_sum.size() == 0) begin
          tests_failed++;
          $display("FAIL rnd_unexpected: sum=%0d err=%0d required no delivery", out_sum, out_err);
        end else if (out_sum !== q_sum[0] || out_err !== q_err[0] || err_cnt !== 8'(q_cnt[0]) ||
                     fault !== q_fault[0]) begin
          tests_failed++;
          $display("FAIL rnd_result#%0d: sum=%0d err=%0d cnt=%0d fault=%0d required %0d %0d %0d %0d",
                   delivered, out_sum, out_err, err_cnt, fault, q_sum[0], q_err[0], q_cnt[0], q_fault[0]);
        end
        if (q_sum.size() != 0) begin
          void'(q_sum.pop_front()); void'(q_err.pop_front());
          void'(q_cnt.pop_front()); void'(q_fault.pop_front());
        end
      end
      if (clr_fault) m_consec = 0;
      if (acc) begin
        gold = 5'(in_a) + 5'(in_b);
        if (force_en) begin
          if (m_err < 255) m_err++;
          m_consec++;
          q_sum.push_back(final_mismatch_sum(gold, force_val));
          q_err.push_back(1'b1);
        end else begin
          m_consec = 0;
          q_sum.push_back(gold);
          q_err.push_back(1'b0);
        end
        q_cnt.push_back(m_err);
        q_fault.push_back(m_consec == 4);
      end
      tick();
      in_valid = 1'b0;
    end
    clr_fault = 1'b0;
    tests_run++;
    if (q_sum.size() != 0 || delivered < 500) begin
      tests_failed++;
      $display("FAIL rnd_drain: pending=%0d delivered=%0d required 0 and >=500", q_sum.size(), delivered);
    end
  endtask

  initial begin
    test_reset();
    test_clean_add();
    test_transient();
    test_persistent();
    test_backpressure();
    test_fault_threshold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/addr4u_result_checker.md
Name: addr4u_result_checker

Overview:
Sequential stage wrapped around one combinational 4-bit unsigned adder instance (A[3:0] + B[3:0] -> O[4:0]).
- Registers operands, drives them to the adder, and compares the adder's 5-bit result against an internal golden sum.
- Retries on mismatch to filter transient faults, then hands the checked result downstream over valid/ready.
- Tracks error statistics and latches a permanent-fault condition for the system controller.

Parameters:
- MAX_RETRY, 2: extra compare cycles allowed after a first mismatch before the result is delivered as erroneous (range 0-7).
- FAULT_THRESH, 4: consecutive erroneous deliveries that force the FAULT state (range 1-15).
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: stage accepts operands.
- in_a, input, 4: operand A.
- in_b, input, 4: operand B.
- add_a, output, 4: operand A to adder, driven straight from the operand register.
- add_b, output, 4: operand B to adder, driven straight from the operand register.
- add_o, input, 5: adder result; combinational from add_a/add_b.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts.
- out_sum, output, 5: delivered sum.
- out_err, output, 1: result failed every compare attempt.
- err_cnt, output, ERR_CNT_W: saturating count of erroneous deliveries.
- fault, output, 1: permanent-fault flag.
- clr_fault, input, 1: leave FAULT; one-cycle pulse.

Behaviour:
- Reset (sync, rst=1 at an edge) clears everything:
  - state=IDLE, operand regs=0, retry_cnt=0, consec_cnt=0.
  - err_cnt=0, out_valid=0, out_sum=0, out_err=0, fault=0.
  - rst mid-transaction discards the transaction; no output is produced.
- Golden sum: zero-extended 5-bit in-register A + B. Carry out is bit 4, no overflow possible.
- Output slot is a single register. slot_free = !out_valid || out_ready.
- in_ready = (state==IDLE) && !rst. It does not depend on out_ready.
- IDLE:
  - in_valid && in_ready at edge k: load operand regs, retry_cnt=0, go CHECK.
- CHECK (starts at cycle k+1):
  - Compare is evaluated only when slot_free; otherwise hold with no count change.
  - Match: load out_sum=add_o, out_err=0, out_valid=1, consec_cnt=0, go IDLE.
    - Best-case latency: out_valid high at cycle k+2.
  - Mismatch with retry_cnt < MAX_RETRY: retry_cnt+1, stay CHECK. Each retry adds one cycle.
  - Mismatch with retry_cnt == MAX_RETRY:
    - Load out_sum per the optional feature, out_err=1, out_valid=1.
    - err_cnt+1, saturating at all-ones. consec_cnt+1.
    - If the new consec_cnt == FAULT_THRESH, go FAULT; else go IDLE.
- FAULT:
  - fault=1, in_ready=0.
  - The pending erroneous result in the slot still drains normally.
  - clr_fault=1 -> fault=0, consec_cnt=0, go IDLE. err_cnt is kept.
  - clr_fault in any other state is ignored.
- Output handshake:
  - out_valid && out_ready -> out_valid=0 next cycle unless the slot is reloaded in the same cycle.
  - out_sum and out_err stay stable while out_valid && !out_ready.
- err_cnt clears only on rst.

Optional Feature:
ADDR4U_CORRECT_EN
- Defined: on final mismatch, out_sum = golden sum (corrected); out_err still 1 and counters still update.
- Undefined: on final mismatch, out_sum = add_o sampled at the last compare cycle.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0 during rst; afterwards out_valid=0, err_cnt=0, fault=0, in_ready=1.
- Clean add: in_a=9, in_b=7 accepted at edge k, out_ready=1 -> out_valid at k+2, out_sum=16, out_err=0. Then 15+15 -> out_sum=30.
- Transient fault: force add_o=0 for the first compare cycle only, operands 3+4 -> one retry, out_sum=7 at k+3, out_err=0, err_cnt=0.
- Persistent fault with MAX_RETRY=2: force add_o=5'h1F, operands 2+2 -> out_valid at k+4, out_err=1, err_cnt=1.
  - out_sum=4 with ADDR4U_CORRECT_EN defined; 31 without.
- Backpressure: out_ready=0 with a result held, new operands 1+1 accepted -> CHECK stalls, first out_sum held stable.
  - Raise out_ready -> both results delivered in order (first result, then 2), no retry counted during the stall.
- Fault threshold: 4 back-to-back persistent-fault transactions with FAULT_THRESH=4 -> fault=1 and in_ready=0 after the 4th.
  - Pulse clr_fault -> fault=0, in_ready=1, err_cnt=4 retained.
